// File: rtl/rv_pkg.sv
// Shared RISC-V core definitions: funct3/res_src encodings,
// the memory-stage FSM states and the EX/MEM bundle.
package rv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic {
    IDLE,
    WAIT
  } mem_state_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] rs2_val;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  res_src;
    logic [2:0]  funct3;
    logic [29:0] pc_p4;
  } ex_mem_t;

  // funct3[1:0] carries the access size for both loads and stores
  function automatic logic is_aligned(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic ok;
    unique case (f3[1:0])
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~a[0];
      2'b10:   ok = (a == 2'b00);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rv_load_align.sv
// Load-data lane select and sign/zero extension.
// Pure combinational; shared with the data cache.
module rv_load_align
  import rv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  a,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] lane;

  always_comb begin
    lane = rdata >> {a, 3'b000};
    data = '0;
    unique case (funct3)
      F3_LB:   data = {{24{lane[7]}}, lane[7:0]};
      F3_LH:   data = {{16{lane[15]}}, lane[15:0]};
      F3_LW:   data = lane;
      F3_LBU:  data = {24'b0, lane[7:0]};
      F3_LHU:  data = {16'b0, lane[15:0]};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/rv_mem_access.sv
// Memory-access pipeline stage: EX/MEM register, data-bus
// driver with wait-state stall, load alignment.
module rv_mem_access
  import rv_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_flush,
  input  logic [31:0]       i_alu_result,
  input  logic [31:0]       i_rs2_val,
  input  logic [4:0]        i_rd,
  input  logic              i_reg_write,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [1:0]        i_res_src,
  input  logic [2:0]        i_funct3,
  input  logic [29:0]       i_pc_p4,
  output logic [ADDR_W-3:0] o_dbus_addr,
  output logic              o_dbus_req,
  output logic              o_dbus_we,
  output logic [3:0]        o_dbus_be,
  output logic [31:0]       o_dbus_wdata,
  input  logic [31:0]       i_dbus_rdata,
  input  logic              i_dbus_ack,
  output logic              o_stall,
  output logic              o_misaligned,
  output logic [4:0]        o_rd,
  output logic              o_reg_write,
  output logic [1:0]        o_res_src,
  output logic [31:0]       o_alu_result,
  output logic [29:0]       o_pc_p4,
  output logic [2:0]        o_funct3,
  output logic [31:0]       o_load_data,
  output logic [31:0]       o_memory_rd_val
);

  ex_mem_t    ex_in;
  ex_mem_t    ex_q;
  mem_state_t state_q;
  mem_state_t state_d;
  logic       flush_q;
  logic       mis_q;
  logic [1:0] a;
  logic       is_mem;
  logic       aligned;
  logic       pending;
  logic       mis;
  logic       stall;
  logic [31:0] ld_ext;

  always_comb begin
    ex_in.alu_result = i_alu_result;
    ex_in.rs2_val    = i_rs2_val;
    ex_in.rd         = i_rd;
    ex_in.reg_write  = i_reg_write;
    ex_in.mem_read   = i_mem_read;
    ex_in.mem_write  = i_mem_write;
    ex_in.res_src    = i_res_src;
    ex_in.funct3     = i_funct3;
    ex_in.pc_p4      = i_pc_p4;
  end

  assign a       = ex_q.alu_result[1:0];
  assign is_mem  = ex_q.mem_read | ex_q.mem_write;
  assign aligned = is_aligned(ex_q.funct3, a);
  assign pending = is_mem & aligned;
  assign mis     = is_mem & ~aligned;
  assign stall   = pending & ~i_dbus_ack;

  // Held flush keeps killing this slot until the bus lets go
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ex_q    <= '0;
      flush_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      mis_q <= mis;
      if (!stall) begin
        ex_q    <= (i_flush | flush_q) ? '0 : ex_in;
        flush_q <= 1'b0;
      end else if (i_flush) begin
        flush_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (pending && !i_dbus_ack) state_d = WAIT;
      WAIT: if (i_dbus_ack)             state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  always_comb begin
    o_dbus_be    = 4'b0000;
    o_dbus_wdata = ex_q.rs2_val;
    unique case (ex_q.funct3[1:0])
      2'b00: o_dbus_wdata = {4{ex_q.rs2_val[7:0]}};
      2'b01: o_dbus_wdata = {2{ex_q.rs2_val[15:0]}};
      default: o_dbus_wdata = ex_q.rs2_val;
    endcase
    if (pending) begin
      if (ex_q.mem_write) begin
        unique case (ex_q.funct3[1:0])
          2'b00:   o_dbus_be = 4'b0001 << a;
          2'b01:   o_dbus_be = 4'b0011 << a;
          default: o_dbus_be = 4'b1111;
        endcase
      end else begin
        o_dbus_be = 4'b1111;
      end
    end
  end

  rv_load_align u_align (
    .rdata  (i_dbus_rdata),
    .a      (a),
    .funct3 (ex_q.funct3),
    .data   (ld_ext)
  );

  assign o_dbus_addr  = ex_q.alu_result[ADDR_W-1:2];
  assign o_dbus_req   = pending;
  assign o_dbus_we    = pending & ex_q.mem_write;
  assign o_stall      = stall;
  assign o_misaligned = mis_q;

  assign o_load_data = (pending && ex_q.mem_read && i_dbus_ack)
                     ? ld_ext : 32'h0;

  assign o_rd            = ex_q.rd;
  assign o_reg_write     = ex_q.reg_write & ~stall & ~flush_q & ~mis;
  assign o_res_src       = ex_q.res_src;
  assign o_alu_result    = ex_q.alu_result;
  assign o_pc_p4         = ex_q.pc_p4;
  assign o_funct3        = ex_q.funct3;
  assign o_memory_rd_val = ex_q.alu_result;

endmodule
